// File: rtl/cam_req_ctrl.sv
// Round-robin front-end sequencer for a 32-entry CAM: arbitrates requesters, strobes the CAM once, returns a tagged response.
// Define CAM_REQ_CTRL_FIXED_PRIO_EN to replace round-robin with fixed priority (lowest requester index wins).
`timescale 1ns/1ps
module cam_req_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REQ    = 2,
  parameter int CAM_LAT    = 1,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W     = (CAM_LAT > 1) ? $clog2(CAM_LAT) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [2*NUM_REQ-1:0]          req_op_i,
  input  logic [ADDR_WIDTH*NUM_REQ-1:0] req_index_i,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data_i,
  output logic                          cam_read_enable_o,
  output logic                          cam_write_enable_o,
  output logic                          cam_search_enable_o,
  output logic [ADDR_WIDTH-1:0]         cam_read_index_o,
  output logic [ADDR_WIDTH-1:0]         cam_write_index_o,
  output logic [DATA_WIDTH-1:0]         cam_write_data_o,
  output logic [DATA_WIDTH-1:0]         cam_search_data_o,
  input  logic                          cam_read_valid_i,
  input  logic [DATA_WIDTH-1:0]         cam_read_value_i,
  input  logic                          cam_search_valid_i,
  input  logic [ADDR_WIDTH-1:0]         cam_search_index_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [ID_W-1:0]               rsp_id_o,
  output logic                          rsp_hit_o,
  output logic                          rsp_err_o,
  output logic [DATA_WIDTH-1:0]         rsp_data_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_SEARCH = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  state_t                  r_state;
  state_t                  w_next;
  logic                    w_any;
  logic [ID_W-1:0]         w_grant;
  logic [NUM_REQ-1:0]      w_ready;
  logic [1:0]              w_op_arr   [NUM_REQ];
  logic [ADDR_WIDTH-1:0]   w_idx_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   w_data_arr [NUM_REQ];
  logic [1:0]              w_sel_op;

  logic [ID_W-1:0]         r_last_grant;
  logic [ID_W-1:0]         r_id;
  logic [1:0]              r_op;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_rd_en;
  logic                    r_wr_en;
  logic                    r_sr_en;
  logic                    r_rsp_valid;
  logic                    r_rsp_hit;
  logic                    r_rsp_err;
  logic [DATA_WIDTH-1:0]   r_rsp_data;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_op_arr[gi]   = req_op_i[2*gi +: 2];
    assign w_idx_arr[gi]  = req_index_i[ADDR_WIDTH*gi +: ADDR_WIDTH];
    assign w_data_arr[gi] = req_data_i[DATA_WIDTH*gi +: DATA_WIDTH];
  end

  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] last, input int off);
    int s;
    s = (int'(last) + off) % NUM_REQ;
    return ID_W'(s);
  endfunction

  // Requester selection; scanning from the far end lets the nearest candidate overwrite.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
`ifdef CAM_REQ_CTRL_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[ID_W'(i)]) begin
        w_any   = 1'b1;
        w_grant = ID_W'(i);
      end else begin
        w_any   = w_any;
      end
    end
`else
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req_valid_i[rr_idx(r_last_grant, i)]) begin
        w_any   = 1'b1;
        w_grant = rr_idx(r_last_grant, i);
      end else begin
        w_any   = w_any;
      end
    end
`endif
  end

  assign w_sel_op = w_op_arr[w_grant];

  // Accept strobe is combinational in IDLE and forced low while reset is asserted.
  always_comb begin
    w_ready = '0;
    if (rst_i && (r_state == S_IDLE) && w_any) begin
      w_ready = NUM_REQ'(1) << w_grant;
    end else begin
      w_ready = '0;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  begin
        if (w_any) w_next = (w_sel_op == OP_RSVD) ? S_RESP : S_ISSUE;
        else       w_next = S_IDLE;
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  begin
        if (r_cnt == CNT_W'(0)) w_next = S_RESP;
        else                    w_next = S_WAIT;
      end
      S_RESP:  begin
        if (rsp_ready_i) w_next = S_IDLE;
        else             w_next = S_RESP;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Request latch, CAM strobes, latency counter and response capture.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_id         <= '0;
      r_op         <= 2'b00;
      r_idx        <= '0;
      r_data       <= '0;
      r_cnt        <= '0;
      r_rd_en      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_sr_en      <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_hit    <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_last_grant <= w_grant;
            r_id         <= w_grant;
            r_op         <= w_sel_op;
            r_idx        <= w_idx_arr[w_grant];
            r_data       <= w_data_arr[w_grant];
            case (w_sel_op)
              OP_READ:   r_rd_en <= 1'b1;
              OP_WRITE:  r_wr_en <= 1'b1;
              OP_SEARCH: r_sr_en <= 1'b1;
              default: begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b1;
                r_rsp_hit   <= 1'b0;
                r_rsp_data  <= '0;
              end
            endcase
          end else begin
            r_rd_en <= 1'b0;
          end
        end
        S_ISSUE: begin
          r_rd_en <= 1'b0;
          r_wr_en <= 1'b0;
          r_sr_en <= 1'b0;
          r_cnt   <= CNT_W'(CAM_LAT - 1);
        end
        S_WAIT: begin
          if (r_cnt == CNT_W'(0)) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            case (r_op)
              OP_READ: begin
                r_rsp_hit  <= cam_read_valid_i;
                r_rsp_data <= cam_read_value_i;
              end
              OP_SEARCH: begin
                r_rsp_hit  <= cam_search_valid_i;
                r_rsp_data <= cam_search_valid_i ? DATA_WIDTH'(cam_search_index_i) : '0;
              end
              default: begin
                r_rsp_hit  <= 1'b1;
                r_rsp_data <= '0;
              end
            endcase
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready_i) r_rsp_valid <= 1'b0;
          else             r_rsp_valid <= 1'b1;
        end
        default: r_rsp_valid <= 1'b0;
      endcase
    end
  end

  assign req_ready_o         = w_ready;
  assign cam_read_enable_o   = r_rd_en;
  assign cam_write_enable_o  = r_wr_en;
  assign cam_search_enable_o = r_sr_en;
  assign cam_read_index_o    = r_idx;
  assign cam_write_index_o   = r_idx;
  assign cam_write_data_o    = r_data;
  assign cam_search_data_o   = r_data;
  assign rsp_valid_o         = r_rsp_valid;
  assign rsp_id_o            = r_id;
  assign rsp_hit_o           = r_rsp_hit;
  assign rsp_err_o           = r_rsp_err;
  assign rsp_data_o          = r_rsp_data;

endmodule

// File: tb/tb_cam_req_ctrl.sv
// Scoreboard bench for cam_req_ctrl with a behavioural 32-entry CAM (latency 1) and hand-computed expectations.
`timescale 1ns/1ps
module tb_cam_req_ctrl;

  typedef struct packed {
    logic        id;
    logic        hit;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [1:0]  req_valid_i = 2'b00;
  logic [1:0]  req_ready_o;
  logic [1:0]  op_a   [2];
  logic [4:0]  idx_a  [2];
  logic [31:0] data_a [2];
  logic [3:0]  req_op_i;
  logic [9:0]  req_index_i;
  logic [63:0] req_data_i;
  logic        cam_read_enable_o, cam_write_enable_o, cam_search_enable_o;
  logic [4:0]  cam_read_index_o, cam_write_index_o;
  logic [31:0] cam_write_data_o, cam_search_data_o;
  logic        cam_read_valid_i = 1'b0;
  logic [31:0] cam_read_value_i = 32'h0;
  logic        cam_search_valid_i = 1'b0;
  logic [4:0]  cam_search_index_i = 5'd0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [0:0]  rsp_id_o;
  logic        rsp_hit_o, rsp_err_o;
  logic [31:0] rsp_data_o;

  rsp_t        exp_q [$];
  rsp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cam_mem [32];
  logic [31:0] cam_vld = 32'h0;

  assign req_op_i    = {op_a[1], op_a[0]};
  assign req_index_i = {idx_a[1], idx_a[0]};
  assign req_data_i  = {data_a[1], data_a[0]};

  cam_req_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REQ(2), .CAM_LAT(1)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_index_i(req_index_i), .req_data_i(req_data_i),
    .cam_read_enable_o(cam_read_enable_o), .cam_write_enable_o(cam_write_enable_o),
    .cam_search_enable_o(cam_search_enable_o),
    .cam_read_index_o(cam_read_index_o), .cam_write_index_o(cam_write_index_o),
    .cam_write_data_o(cam_write_data_o), .cam_search_data_o(cam_search_data_o),
    .cam_read_valid_i(cam_read_valid_i), .cam_read_value_i(cam_read_value_i),
    .cam_search_valid_i(cam_search_valid_i), .cam_search_index_i(cam_search_index_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_hit_o(rsp_hit_o), .rsp_err_o(rsp_err_o), .rsp_data_o(rsp_data_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] en_of(input logic [1:0] op);
    case (op)
      2'b00:   return 3'b100;
      2'b01:   return 3'b010;
      2'b10:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Behavioural CAM, one-cycle latency; lowest matching index wins a search.
  always @(posedge clk) begin
    cam_read_valid_i   <= 1'b0;
    cam_read_value_i   <= 32'h0;
    cam_search_valid_i <= 1'b0;
    cam_search_index_i <= 5'd0;
    if (cam_write_enable_o) begin
      cam_mem[cam_write_index_o] <= cam_write_data_o;
      cam_vld[cam_write_index_o] <= 1'b1;
    end
    if (cam_read_enable_o) begin
      cam_read_valid_i <= cam_vld[cam_read_index_o];
      cam_read_value_i <= cam_mem[cam_read_index_o];
    end
    if (cam_search_enable_o) begin
      for (int i = 31; i >= 0; i--) begin
        if (cam_vld[i] && cam_mem[i] == cam_search_data_o) begin
          cam_search_valid_i <= 1'b1;
          cam_search_index_i <= 5'(i);
        end
      end
    end
  end

  // Monitor: every accepted response is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rsp_valid_o && rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id %0d data %0h, required no response", rsp_id_o, rsp_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_id",   64'(rsp_id_o),   64'(mon_e.id));
        chk("rsp_hit",  64'(rsp_hit_o),  64'(mon_e.hit));
        chk("rsp_err",  64'(rsp_err_o),  64'(mon_e.err));
        chk("rsp_data", 64'(rsp_data_o), 64'(mon_e.data));
      end
    end
  end

  // One complete operation by requester r; checks handshake, CAM strobes and latency.
  task automatic transact(input int r, input logic [1:0] op, input logic [4:0] idx,
                          input logic [31:0] data, input logic hit, input logic [31:0] rdata,
                          input int lat);
    int n;
    @(posedge clk); #1;
    op_a[r] = op; idx_a[r] = idx; data_a[r] = data;
    req_valid_i[r] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready_o[r] && n < 20) begin n++; @(negedge clk); end
    if (n >= 20) begin
      chk("accept_timeout", 64'(n), 64'(0));
      req_valid_i[r] = 1'b0;
      return;
    end
    chk("ready_onehot", 64'(req_ready_o), 64'(2'b01 << r));
    exp_q.push_back('{id: 1'(r), hit: hit, err: (op == 2'b11), data: rdata});
    @(posedge clk); #1;
    req_valid_i[r] = 1'b0;
    @(negedge clk);
    chk("ready_pulse", 64'(req_ready_o), 64'(0));
    chk("cam_enables", 64'({cam_read_enable_o, cam_write_enable_o, cam_search_enable_o}), 64'(en_of(op)));
    if (op == 2'b00)      chk("read_index", 64'(cam_read_index_o), 64'(idx));
    else if (op == 2'b01) chk("write_ixd",  64'({cam_write_index_o, cam_write_data_o}), {27'd0, idx, data});
    else if (op == 2'b10) chk("search_data", 64'(cam_search_data_o), 64'(data));
    n = 1;
    if (lat > 1) begin
      @(negedge clk); n = 2;
      chk("enables_drop", 64'({cam_read_enable_o, cam_write_enable_o, cam_search_enable_o}), 64'(0));
    end
    while (!rsp_valid_o && n < 20) begin @(negedge clk); n++; end
    chk("rsp_latency", 64'(n), 64'(lat));
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, 64'({req_ready_o, rsp_valid_o, rsp_hit_o, rsp_err_o, rsp_id_o,
                 cam_read_enable_o, cam_write_enable_o, cam_search_enable_o}), 64'(0));
    chk({nm, "_data"}, {rsp_data_o, cam_write_data_o}, 64'(0));
  endtask

  initial begin
    int n;
    logic [1:0] exp_g;
    for (int i = 0; i < 2; i++) begin op_a[i] = 2'b00; idx_a[i] = 5'd0; data_a[i] = 32'h0; end
    repeat (3) @(negedge clk);
    chk_all_zero("reset_state");
    rst_i = 1'b1;
    @(negedge clk);

    transact(0, 2'b01, 5'd3, 32'hDEADBEEF, 1'b1, 32'h0, 3);
    @(negedge clk);
    transact(1, 2'b00, 5'd3, 32'h0, 1'b1, 32'hDEADBEEF, 3);
    @(negedge clk);
    transact(0, 2'b10, 5'd0, 32'hDEADBEEF, 1'b1, 32'h3, 3);
    @(negedge clk);
    transact(0, 2'b10, 5'd0, 32'h12345678, 1'b0, 32'h0, 3);
    @(negedge clk);
    transact(1, 2'b00, 5'd7, 32'h0, 1'b0, 32'h0, 3);
    @(negedge clk);
    transact(1, 2'b11, 5'd0, 32'h0, 1'b0, 32'h0, 1);
    @(negedge clk);

    // Both requesters valid continuously for six grants.
    @(posedge clk); #1;
    op_a[0] = 2'b00; idx_a[0] = 5'd3; op_a[1] = 2'b00; idx_a[1] = 5'd3;
    req_valid_i = 2'b11;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      @(negedge clk);
      while (req_ready_o == 2'b00 && n < 20) begin n++; @(negedge clk); end
`ifdef CAM_REQ_CTRL_FIXED_PRIO_EN
      exp_g = 2'd0;
`else
      exp_g = 2'(k % 2);
`endif
      chk("rr_grant", 64'(req_ready_o), 64'(2'b01 << exp_g));
      exp_q.push_back('{id: exp_g[0], hit: 1'b1, err: 1'b0, data: 32'hDEADBEEF});
      @(posedge clk); #1;
      if (k == 5) req_valid_i = 2'b00;
    end
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin n++; @(negedge clk); end
    chk("rr_drain", 64'(exp_q.size()), 64'(0));
    @(negedge clk);

    // Response backpressure: fields stay put and nobody is accepted.
    rsp_ready_i = 1'b0;
    transact(0, 2'b00, 5'd3, 32'h0, 1'b1, 32'hDEADBEEF, 3);
    @(posedge clk); #1;
    op_a[1] = 2'b00; idx_a[1] = 5'd3; req_valid_i[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_fields", {26'd0, rsp_valid_o, rsp_id_o, rsp_hit_o, rsp_err_o, req_ready_o, rsp_data_o},
          {26'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 32'hDEADBEEF});
    end
    @(posedge clk); #1;
    rsp_ready_i = 1'b1;
    req_valid_i[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset asserted during WAIT abandons the op.
    @(posedge clk); #1;
    op_a[0] = 2'b00; idx_a[0] = 5'd3; req_valid_i[0] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready_o[0] && n < 20) begin n++; @(negedge clk); end
    chk("rst_accept", 64'(n < 20), 64'(1));
    @(posedge clk); #1;
    req_valid_i[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk_all_zero("reset_in_wait");
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    transact(1, 2'b00, 5'd3, 32'h0, 1'b1, 32'hDEADBEEF, 3);
    @(negedge clk);

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
